window_gen_3x3: RTL and testbench
=================================

# window_gen_3x3

Upstream neighbour of the 3x3 median filter. It takes a raster-order 8-bit pixel stream, one pixel per accepted cycle, and buffers the two previous image rows in internal line buffers. It presents the full 3x3 neighbourhood of each interior pixel on nine parallel outputs, with a one-cycle window-valid strobe for the median stage.

## Interface

Parameters:
- IMG_W, default 64: pixels per row; must be ≥ 3.
- IMG_H, default 64: rows per frame; must be ≥ 3.

Ports:
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pix_valid_i  in  1  pixel strobe; pix_i is accepted on every rising edge where this is 1.
- pix_i  in  8  pixel value, raster order, row-major, top-left first.
- sof_i  in  1  start of frame; sampled only when pix_valid_i=1; marks that pixel as (row 0, col 0).
- en_o  out  1  window valid, one cycle per produced window.
- data_o0..data_o8  out  8 each  window pixels, row-major: o0..o2 top row (r-2), o3..o5 middle row (r-1), o6..o8 current row (r); o0/o3/o6 are column c-2, o2/o5/o8 are column c.
- frame_done_o  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation

- State:
  - Column counter col, width clog2(IMG_W).
  - Row counter row, width clog2(IMG_H).
  - Line buffers lb0 (row r-2) and lb1 (row r-1), IMG_W x 8 each.
  - 3x3 window register array w[0..8].
  - en_o and frame_done_o registers.
- Position of an accepted pixel: if sof_i=1, (0,0); otherwise (row,col).
- On each accepted pixel at column c:
  - top = lb0[c], mid = lb1[c].
  - Update lb0[c] ← lb1[c] and lb1[c] ← pix_i.
  - Shift the window left: w0←w1, w1←w2, w2←top; w3←w4, w4←w5, w5←mid; w6←w7, w7←w8, w8←pix_i.
- Counter advance:
  - col increments.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both counters wrap to 0.
  - sof_i=1 forces the next position to (0,1), row 0.
- en_o ← 1 when the accepted pixel's position has row ≥ 2 and col ≥ 2; else 0. No padding: border positions never produce a window. Exactly (IMG_H-2)·(IMG_W-2) windows per frame.
- frame_done_o ← 1 when the accepted pixel's position is (IMG_H-1, IMG_W-1); else 0.
- Cycle with pix_valid_i=0: counters, line buffers and window hold; en_o and frame_done_o ← 0.
- Line buffer contents are not reset. Stale data never reaches a valid window because row ≥ 2 requires both buffers to have been rewritten in the current frame.
- sof_i mid-frame: the partial frame is abandoned and no frame_done_o is issued for it. The new frame starts at the sof pixel.

## Timing

- Reset values (async, while rst=0): col=0, row=0, w[0..8]=0, data_o0..8=0, en_o=0, frame_done_o=0.
- First edge after rst deasserts: normal operation. Reset mid-frame discards the position; the next pixel is treated as (0,0) whether or not sof_i is asserted.
- Latency: data_o0..8 and en_o are valid in the cycle after the edge that accepts the window's bottom-right pixel (c, r). Registered outputs, one cycle.
- en_o is a single-cycle strobe per window. data_o holds its value until the next accepted pixel, so the downstream stage may sample across multiple cycles.
- Throughput: one pixel per clock; arbitrary bubbles on pix_valid_i permitted. No backpressure.
- Simultaneous sof_i with the last pixel of a frame: sof wins. The position is (0,0) and frame_done_o=0.

## Test plan

All tests use IMG_W=4, IMG_H=4.

- **Reset:** hold rst=0 with random inputs → en_o=0, frame_done_o=0, all data_o=0.
- **Basic frame:** stream pixels 1..16 back-to-back, sof_i with pixel 1 → en_o pulses exactly 4 times, one cycle after pixels 11, 12, 15, 16.
  - After pixel 11: window 1,2,3,5,6,7,9,10,11.
  - After pixel 16: window 6,7,8,10,11,12,14,15,16.
  - frame_done_o pulses one cycle after pixel 16.
- **Bubbles:** same stream with pix_valid_i=0 inserted every other cycle → identical windows and order; en_o never high during bubble-following cycles.
- **Back-to-back frames:** second frame of values 101..116 immediately after the first → first window after pixel 111 is 101,102,103,105,106,107,109,110,111, with no mixing from frame 1.
- **Reset mid-frame:** rst pulsed low after 6 pixels, then stream 1..16 → behaviour identical to the basic frame.
- **sof resync:** 5 pixels of junk, then sof_i with 1..16 → no frame_done_o for the junk; windows identical to the basic frame.

Source files
------------

// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
// Builds the 3x3 neighbourhood of every interior pixel from a raster-order
// 8-bit pixel stream. Two line buffers hold rows r-2 and r-1. A nine-entry
// shift window presents the neighbourhood together with a one-cycle valid
// strobe for the downstream median stage.
//
// Ports
//   clk            sole clock, rising edge
//   rst            asynchronous, active-low reset
//   pix_valid_i    pixel strobe; pix_i/sof_i accepted when high
//   pix_i[7:0]     pixel value, raster order, top-left first
//   sof_i          start of frame; forces the accepted pixel to (0,0)
//   en_o           one-cycle window-valid strobe
//   data_o0..8     window pixels, row-major (o0..o2 = row r-2, o6..o8 = row r)
//   frame_done_o   one-cycle pulse after the last pixel of a frame
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid_i,
  input  logic [7:0] pix_i,
  input  logic       sof_i,
  output logic       en_o,
  output logic [7:0] data_o0,
  output logic [7:0] data_o1,
  output logic [7:0] data_o2,
  output logic [7:0] data_o3,
  output logic [7:0] data_o4,
  output logic [7:0] data_o5,
  output logic [7:0] data_o6,
  output logic [7:0] data_o7,
  output logic [7:0] data_o8,
  output logic       frame_done_o
);

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN_N = 9;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(2);

  // Position counters (point at the next expected pixel)
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  // Window registers and registered strobes
  logic [PIX_W-1:0] w_q [WIN_N];
  logic [PIX_W-1:0] w_d [WIN_N];
  logic             en_q, en_d;
  logic             done_q, done_d;

  // Line buffers: lb0 holds row r-2, lb1 holds row r-1 (not reset)
  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];

  // Position of the pixel presented this cycle and its column taps
  logic [COL_W-1:0] pos_col;
  logic [ROW_W-1:0] pos_row;
  logic [PIX_W-1:0] top;
  logic [PIX_W-1:0] mid;
  logic             lb_we;

  // Position, taps and next-state logic
  always_comb begin
    pos_col = sof_i ? '0 : col_q;
    pos_row = sof_i ? '0 : row_q;
    top     = lb0_q[pos_col];
    mid     = lb1_q[pos_col];

    col_d  = col_q;
    row_d  = row_q;
    w_d    = w_q;
    en_d   = 1'b0;
    done_d = 1'b0;
    lb_we  = 1'b0;

    if (pix_valid_i) begin
      lb_we = 1'b1;

      // Shift each window row left and insert the new column on the right
      w_d[0] = w_q[1];
      w_d[1] = w_q[2];
      w_d[2] = top;
      w_d[3] = w_q[4];
      w_d[4] = w_q[5];
      w_d[5] = mid;
      w_d[6] = w_q[7];
      w_d[7] = w_q[8];
      w_d[8] = pix_i;

      // Interior positions only; borders never produce a window
      en_d   = (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);
      done_d = (pos_row == ROW_LAST) && (pos_col == COL_LAST);

      // Advance from the accepted position so sof re-anchors the raster
      if (pos_col == COL_LAST) begin
        col_d = '0;
        row_d = (pos_row == ROW_LAST) ? '0 : pos_row + ROW_W'(1);
      end else begin
        col_d = pos_col + COL_W'(1);
        row_d = pos_row;
      end
    end
  end

  // Counter, window and strobe registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < int'(WIN_N); i++) begin
        w_q[i] <= '0;
      end
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      en_q   <= en_d;
      done_q <= done_d;
      for (int i = 0; i < int'(WIN_N); i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  // Line buffer storage: the column's r-1 value ages into r-2
  always_ff @(posedge clk) begin
    if (lb_we) begin
      lb0_q[pos_col] <= mid;
      lb1_q[pos_col] <= pix_i;
    end
  end

  assign en_o         = en_q;
  assign frame_done_o = done_q;
  assign data_o0      = w_q[0];
  assign data_o1      = w_q[1];
  assign data_o2      = w_q[2];
  assign data_o3      = w_q[3];
  assign data_o4      = w_q[4];
  assign data_o5      = w_q[5];
  assign data_o6      = w_q[6];
  assign data_o7      = w_q[7];
  assign data_o8      = w_q[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
// Self-checking bench for window_gen_3x3 at IMG_W=4, IMG_H=4. A reference
// model stores the current frame as a 2-D image and cuts the expected 3x3
// neighbourhood directly out of it.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_valid_i = 1'b0;
  logic [7:0] pix_i = 8'd0;
  logic       sof_i = 1'b0;
  logic       en_o;
  logic [7:0] data_o0, data_o1, data_o2, data_o3, data_o4;
  logic [7:0] data_o5, data_o6, data_o7, data_o8;
  logic       frame_done_o;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk          (clk),
    .rst          (rst),
    .pix_valid_i  (pix_valid_i),
    .pix_i        (pix_i),
    .sof_i        (sof_i),
    .en_o         (en_o),
    .data_o0      (data_o0),
    .data_o1      (data_o1),
    .data_o2      (data_o2),
    .data_o3      (data_o3),
    .data_o4      (data_o4),
    .data_o5      (data_o5),
    .data_o6      (data_o6),
    .data_o7      (data_o7),
    .data_o8      (data_o8),
    .frame_done_o (frame_done_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixel image of the current frame plus next position
  logic [7:0]  img [H][W];
  int          m_r, m_c;
  logic [71:0] exp_win;
  bit          win_known;
  int          en_cnt, done_cnt;
  logic [71:0] caps [$];
  logic [71:0] ref_caps [$];

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] dut_win();
    return {data_o0, data_o1, data_o2, data_o3, data_o4,
            data_o5, data_o6, data_o7, data_o8};
  endfunction

  // One clock of stimulus, model update and output checks
  task automatic step(input logic v, input logic [7:0] p, input logic s);
    logic e_en, e_done;
    int   r, c;
    pix_valid_i = v;
    pix_i       = p;
    sof_i       = s;
    @(posedge clk);
    e_en   = 1'b0;
    e_done = 1'b0;
    if (v) begin
      if (s) begin
        m_r = 0;
        m_c = 0;
      end
      r = m_r;
      c = m_c;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        e_en      = 1'b1;
        exp_win   = {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                     img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                     img[r][c-2],   img[r][c-1],   img[r][c]};
        win_known = 1'b1;
      end else begin
        win_known = 1'b0;
      end
      e_done = (r == H - 1) && (c == W - 1);
      m_c++;
      if (m_c == W) begin
        m_c = 0;
        m_r = (m_r + 1) % H;
      end
    end
    #1;
    check("en", 72'(en_o), 72'(e_en));
    check("frame_done", 72'(frame_done_o), 72'(e_done));
    if (win_known) check("window", dut_win(), exp_win);
    if (en_o) caps.push_back(dut_win());
    en_cnt   += int'(en_o);
    done_cnt += int'(frame_done_o);
  endtask

  // Hold reset with random inputs; every output must read zero
  task automatic do_reset();
    rst = 1'b0;
    m_r = 0;
    m_c = 0;
    exp_win   = '0;
    win_known = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pix_valid_i = 1'($urandom);
      pix_i       = 8'($urandom);
      sof_i       = 1'($urandom);
      @(posedge clk);
      #1;
      check("rst_en", 72'(en_o), 72'd0);
      check("rst_done", 72'(frame_done_o), 72'd0);
      check("rst_data", dut_win(), 72'd0);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic clear_stats();
    caps.delete();
    en_cnt   = 0;
    done_cnt = 0;
  endtask

  // Frame of base..base+15 with sof on the first pixel, optional bubbles
  task automatic send_frame(input int base, input bit bubbles);
    for (int i = 0; i < W * H; i++) begin
      step(1'b1, 8'(base + i), i == 0);
      if (bubbles) step(1'b0, 8'($urandom), 1'($urandom));
    end
  endtask

  task automatic check_vs_basic(input string tag);
    check({tag, "_en_cnt"}, 72'(en_cnt), 72'd4);
    check({tag, "_done_cnt"}, 72'(done_cnt), 72'd1);
    check({tag, "_caps"}, 72'(caps.size()), 72'(ref_caps.size()));
    if (caps.size() == ref_caps.size()) begin
      for (int i = 0; i < caps.size(); i++) check({tag, "_win_order"}, caps[i], ref_caps[i]);
    end
  endtask

  initial begin
    do_reset();

    // Basic frame
    clear_stats();
    send_frame(1, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("basic_en_cnt", 72'(en_cnt), 72'd4);
    check("basic_done_cnt", 72'(done_cnt), 72'd1);
    check("basic_caps", 72'(caps.size()), 72'd4);
    if (caps.size() == 4) begin
      check("basic_win_p11", caps[0],
            {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11});
      check("basic_win_p16", caps[3],
            {8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12, 8'd14, 8'd15, 8'd16});
    end
    ref_caps = caps;

    // Bubbles every other cycle
    clear_stats();
    send_frame(1, 1'b1);
    check_vs_basic("bubble");

    // Back-to-back frames
    clear_stats();
    send_frame(1, 1'b0);
    caps.delete();
    send_frame(101, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check("b2b_caps", 72'(caps.size()), 72'd4);
    if (caps.size() > 0)
      check("b2b_win_p111", caps[0],
            {8'd101, 8'd102, 8'd103, 8'd105, 8'd106, 8'd107, 8'd109, 8'd110, 8'd111});

    // Reset mid-frame, then 1..16 without sof
    for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), i == 0);
    do_reset();
    clear_stats();
    for (int i = 0; i < W * H; i++) step(1'b1, 8'(i + 1), 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check_vs_basic("rst_mid");

    // sof resync after junk that started mid-frame
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0);
    clear_stats();
    for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
    check("junk_done", 72'(done_cnt), 72'd0);
    clear_stats();
    send_frame(1, 1'b0);
    step(1'b0, 8'd0, 1'b0);
    check_vs_basic("resync");

    // sof coinciding with the last pixel of a frame
    for (int i = 0; i < W * H - 1; i++) step(1'b1, 8'(i + 1), i == 0);
    clear_stats();
    step(1'b1, 8'd77, 1'b1);
    check("sof_last_done", 72'(done_cnt), 72'd0);

    // Random traffic with bubbles and occasional resync
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 40) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
